double_exp_scheduler: RTL
=========================

Name: double_exp_scheduler

Overview:
- Shares one double_exp_221_1000 exponentiation unit between N requesters.
- Arbitrates requesters round-robin and latches the winner's carry-save operand (xs, xc).
- Sequences the unit's load protocol: ld high, ld low setup gap, then a one-cycle operand issue.
- Waits for dn, returns the carry-save result (ys, yc) tagged with the requester id, and sits between the request fabric and the exponentiation unit.

Parameters:
- N, 4, number of requesters (2..16).
- IDW, 2, requester id width (ceil log2 N, minimum 1).
- W, 8, operand/result width; must equal the unit's 8-bit bus.
- LD_CYCLES, 8, cycles exp_ld is held high.
- SETUP_CYCLES, 6, cycles exp_ld is low before the operand issue.
- TIMEOUT, 1023, maximum WAIT cycles before the job aborts.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  [0:N-1]  request per requester; held until ack.
- req_xs  in  [0:N*W-1]  operand sum words; requester i at bits [i*W : i*W+W-1].
- req_xc  in  [0:N*W-1]  operand carry words, same packing.
- ack  out  [0:N-1]  one-cycle grant pulse; operand captured.
- rsp_vld  out  1  one-cycle result strobe.
- rsp_id  out  [0:IDW-1]  requester served.
- rsp_ys  out  [0:W-1]  result sum word.
- rsp_yc  out  [0:W-1]  result carry word.
- rsp_err  out  1  with rsp_vld: timeout, result zeroed.
- busy  out  1  high in any state except IDLE.
- exp_ld  out  1  to the unit's ld.
- exp_xs  out  [0:W-1]  to the unit's xs.
- exp_xc  out  [0:W-1]  to the unit's xc.
- exp_dn  in  1  from the unit's dn.
- exp_ys  in  [0:W-1]  from the unit's ys.
- exp_yc  in  [0:W-1]  from the unit's yc.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; round-robin pointer=0; counters=0.
  - All outputs 0: ack, rsp_*, busy, exp_ld, exp_xs, exp_xc.
  - An in-flight job is dropped silently, with no rsp_vld and no ack.
  - Every job starts with a full LOAD, so the unit is never left mid-protocol.
- All outputs are registered.
- States: IDLE -> LOAD -> SETUP -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - If any req is high, grant the first requester at or after the pointer (wrapping), latch its xs/xc/id, then go to LOAD.
  - Pointer becomes (id+1) mod N.
  - If no req is high, stay in IDLE.
- LOAD:
  - exp_ld=1 for exactly LD_CYCLES cycles.
  - ack[id]=1 in the first LOAD cycle only.
- SETUP: exp_ld=0 for exactly SETUP_CYCLES cycles.
- ISSUE:
  - One cycle with exp_xs/exp_xc = latched operand.
  - This cycle is LD_CYCLES+SETUP_CYCLES (14) cycles after the first exp_ld=1 cycle.
  - exp_xs/exp_xc are 0 in every other state.
- WAIT:
  - Watch for a rising edge of exp_dn (exp_dn=1 while the registered previous exp_dn=0).
  - A dn level already high on entry is ignored until it falls and rises again.
  - On the edge, capture exp_ys/exp_yc in that same cycle and go to RESP.
  - The cycle counter saturates at TIMEOUT; on reaching it, go to RESP with the error flagged.
- RESP:
  - rsp_vld=1 for one cycle with rsp_id, rsp_ys, rsp_yc.
  - rsp_err=1 only on timeout, with ys=yc=0.
  - Next state is IDLE.
- Timing:
  - No request is sampled outside IDLE; a requester keeps req high until it sees ack.
  - Requester i must drop req in the cycle after ack, otherwise it is re-arbitrated as a new job.
  - Back-to-back jobs: minimum gap is one IDLE cycle between RESP and the next LOAD.
- Latency: rsp_vld is asserted D+2 cycles after ISSUE, where D = cycles from ISSUE to the dn edge.
- The req change, the dn edge and reset can coincide with any state; reset always wins.

Decomposition:
- Include file double_exp_sched_defs.v holds:
  - state encodings (3-bit: IDLE=0, LOAD=1, SETUP=2, ISSUE=3, WAIT=4, RESP=5);
  - default LD_CYCLES, SETUP_CYCLES and TIMEOUT values.
- One sub-module, rr_arbiter: combinational round-robin pick from (req, pointer) returning a valid flag and an id.
- Counters and the FSM live in double_exp_scheduler.

Test Plan:
- Reset then single job: req[2]=1 with xs=8'h5A, xc=8'h00.
  - ack[2] pulses once.
  - exp_ld is high for exactly 8 cycles, then low for 6 cycles.
  - exp_xs=8'h5A in exactly one cycle.
  - A model dn edge 20 cycles later gives rsp_vld with rsp_id=2 and ys/yc matching the model.
- All four req high together: grants in order 0,1,2,3, one job each, no overlap.
  - A new req[0] arriving during job 3 is granted after job 3.
- dn held high from before WAIT: no response until dn falls and rises.
  - The response is captured on that rising edge.
- dn never rises (TIMEOUT=15 for the test): rsp_vld with rsp_err=1, ys=yc=0 at WAIT cycle 15, then IDLE.
- rst_n pulsed low mid-SETUP: all outputs are 0 immediately and asynchronously, with no rsp_vld.
  - A req[1] held after reset gets a fresh full 8+6 sequence.
- Pointer wrap at N=4: after serving requester 3 with req[0] and req[3] both high, requester 0 is granted next.

Source files
------------

// File: rtl/double_exp_scheduler_pkg.sv
// Shared types and defaults for the double_exp_scheduler slice: FSM state
// encoding, default protocol timings and small index helpers.
package double_exp_scheduler_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_SETUP = 3'd2,
      ST_ISSUE = 3'd3,
      ST_WAIT  = 3'd4,
      ST_RESP  = 3'd5
   } state_e;

   localparam int DEF_LD_CYCLES    = 8;
   localparam int DEF_SETUP_CYCLES = 6;
   localparam int DEF_TIMEOUT      = 1023;

   // One counter serves LOAD, SETUP and the WAIT timeout.
   localparam int CNT_W = 16;
   localparam logic [CNT_W-1:0] CNT_ONE = 16'd1;

   // (a + b) mod n for a < n and b < n.
   function automatic int wrap_add(input int a, input int b, input int n);
      int s;
      s = a + b;
      if (s >= n) begin
         s = s - n;
      end else begin
         s = s;
      end
      return s;
   endfunction

endpackage

// File: rtl/double_exp_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick; returns the first requester at
// or after ptr (wrapping) together with a valid flag.
module rr_arbiter
   import double_exp_scheduler_pkg::*;
#(
   parameter int N   = 4,
   parameter int IDW = 2
) (
   input  logic [N-1:0]   req,
   input  logic [IDW-1:0] ptr,
   output logic           vld,
   output logic [IDW-1:0] id
);

   logic [IDW-1:0] idx_s;

   // Scan from the pointer; the first hit locks the result.
   always_comb begin
      vld   = 1'b0;
      id    = '0;
      idx_s = '0;
      for (int k = 0; k < N; k++) begin
         idx_s = IDW'(wrap_add(int'(ptr), k, N));
         if (!vld && req[idx_s]) begin
            vld = 1'b1;
            id  = idx_s;
         end else begin
            vld = vld;
         end
      end
   end

endmodule

// File: rtl/double_exp_scheduler.sv
// double_exp_scheduler: shares one double_exp_221_1000 unit between N
// requesters, sequencing its ld/setup/issue protocol and returning tagged results.
module double_exp_scheduler
   import double_exp_scheduler_pkg::*;
#(
   parameter int N            = 4,
   parameter int IDW          = 2,
   parameter int W            = 8,
   parameter int LD_CYCLES    = DEF_LD_CYCLES,
   parameter int SETUP_CYCLES = DEF_SETUP_CYCLES,
   parameter int TIMEOUT      = DEF_TIMEOUT
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [N-1:0]   req,
   input  logic [N*W-1:0] req_xs,
   input  logic [N*W-1:0] req_xc,
   output logic [N-1:0]   ack,
   output logic           rsp_vld,
   output logic [IDW-1:0] rsp_id,
   output logic [W-1:0]   rsp_ys,
   output logic [W-1:0]   rsp_yc,
   output logic           rsp_err,
   output logic           busy,
   output logic           exp_ld,
   output logic [W-1:0]   exp_xs,
   output logic [W-1:0]   exp_xc,
   input  logic           exp_dn,
   input  logic [W-1:0]   exp_ys,
   input  logic [W-1:0]   exp_yc
);

   localparam logic [N-1:0]     ACK_ONE   = {{(N-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] LD_LAST   = CNT_W'(LD_CYCLES - 1);
   localparam logic [CNT_W-1:0] SU_LAST   = CNT_W'(SETUP_CYCLES - 1);
   localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] TMO_SAT   = CNT_W'(TIMEOUT);
   localparam logic [IDW-1:0]   ID_LAST   = IDW'(N - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [IDW-1:0]   ptr_q, ptr_d;
   logic [IDW-1:0]   id_q, id_d;
   logic [W-1:0]     xs_q, xs_d, xc_q, xc_d;
   logic [W-1:0]     ys_q, ys_d, yc_q, yc_d;
   logic             err_q, err_d;
   logic             dn_prev_q;

   logic [N-1:0]     ack_q, ack_d;
   logic             rsp_vld_q, rsp_vld_d;
   logic [IDW-1:0]   rsp_id_q, rsp_id_d;
   logic [W-1:0]     rsp_ys_q, rsp_ys_d, rsp_yc_q, rsp_yc_d;
   logic             rsp_err_q, rsp_err_d;
   logic             busy_q, busy_d;
   logic             exp_ld_q, exp_ld_d;
   logic [W-1:0]     exp_xs_q, exp_xs_d, exp_xc_q, exp_xc_d;

   logic             arb_vld_s;
   logic [IDW-1:0]   arb_id_s;
   logic [W-1:0]     sel_xs_s, sel_xc_s;
   logic             dn_rise_s;

   rr_arbiter #(
      .N   (N),
      .IDW (IDW)
   ) u_arb (
      .req (req),
      .ptr (ptr_q),
      .vld (arb_vld_s),
      .id  (arb_id_s)
   );

   assign dn_rise_s = exp_dn & ~dn_prev_q;

   // Operand mux for the arbitration winner, constant slices only.
   always_comb begin
      sel_xs_s = '0;
      sel_xc_s = '0;
      for (int i = 0; i < N; i++) begin
         if (arb_id_s == IDW'(i)) begin
            sel_xs_s = req_xs[i*W +: W];
            sel_xc_s = req_xc[i*W +: W];
         end else begin
            sel_xs_s = sel_xs_s;
         end
      end
   end

   // State register, job context and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         ptr_q     <= '0;
         id_q      <= '0;
         xs_q      <= '0;
         xc_q      <= '0;
         ys_q      <= '0;
         yc_q      <= '0;
         err_q     <= 1'b0;
         dn_prev_q <= 1'b0;
         ack_q     <= '0;
         rsp_vld_q <= 1'b0;
         rsp_id_q  <= '0;
         rsp_ys_q  <= '0;
         rsp_yc_q  <= '0;
         rsp_err_q <= 1'b0;
         busy_q    <= 1'b0;
         exp_ld_q  <= 1'b0;
         exp_xs_q  <= '0;
         exp_xc_q  <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         ptr_q     <= ptr_d;
         id_q      <= id_d;
         xs_q      <= xs_d;
         xc_q      <= xc_d;
         ys_q      <= ys_d;
         yc_q      <= yc_d;
         err_q     <= err_d;
         dn_prev_q <= exp_dn;
         ack_q     <= ack_d;
         rsp_vld_q <= rsp_vld_d;
         rsp_id_q  <= rsp_id_d;
         rsp_ys_q  <= rsp_ys_d;
         rsp_yc_q  <= rsp_yc_d;
         rsp_err_q <= rsp_err_d;
         busy_q    <= busy_d;
         exp_ld_q  <= exp_ld_d;
         exp_xs_q  <= exp_xs_d;
         exp_xc_q  <= exp_xc_d;
      end
   end

   // Next state, counter and job context.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ptr_d   = ptr_q;
      id_d    = id_q;
      xs_d    = xs_q;
      xc_d    = xc_q;
      ys_d    = ys_q;
      yc_d    = yc_q;
      err_d   = err_q;
      case (state_q)
         ST_IDLE: begin
            if (arb_vld_s) begin
               state_d = ST_LOAD;
               cnt_d   = '0;
               id_d    = arb_id_s;
               ptr_d   = (arb_id_s == ID_LAST) ? '0 : arb_id_s + IDW'(1'b1);
               xs_d    = sel_xs_s;
               xc_d    = sel_xc_s;
               ys_d    = '0;
               yc_d    = '0;
               err_d   = 1'b0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_LOAD: begin
            if (cnt_q == LD_LAST) begin
               state_d = ST_SETUP;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_SETUP: begin
            if (cnt_q == SU_LAST) begin
               state_d = ST_ISSUE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_ISSUE: begin
            state_d = ST_WAIT;
            cnt_d   = '0;
         end
         ST_WAIT: begin
            // A dn edge wins over a timeout landing in the same cycle.
            if (dn_rise_s) begin
               state_d = ST_RESP;
               ys_d    = exp_ys;
               yc_d    = exp_yc;
               err_d   = 1'b0;
            end else if (cnt_q >= TMO_LAST) begin
               state_d = ST_RESP;
               cnt_d   = TMO_SAT;
               ys_d    = '0;
               yc_d    = '0;
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Output values for the current state; they appear one cycle later.
   always_comb begin
      ack_d     = '0;
      rsp_vld_d = 1'b0;
      rsp_id_d  = '0;
      rsp_ys_d  = '0;
      rsp_yc_d  = '0;
      rsp_err_d = 1'b0;
      busy_d    = (state_q != ST_IDLE);
      exp_ld_d  = 1'b0;
      exp_xs_d  = '0;
      exp_xc_d  = '0;
      case (state_q)
         ST_LOAD: begin
            exp_ld_d = 1'b1;
            if (cnt_q == '0) begin
               ack_d = ACK_ONE << id_q;
            end else begin
               ack_d = '0;
            end
         end
         ST_ISSUE: begin
            exp_xs_d = xs_q;
            exp_xc_d = xc_q;
         end
         ST_RESP: begin
            rsp_vld_d = 1'b1;
            rsp_id_d  = id_q;
            rsp_ys_d  = ys_q;
            rsp_yc_d  = yc_q;
            rsp_err_d = err_q;
         end
         default: begin
            exp_ld_d = 1'b0;
         end
      endcase
   end

   assign ack     = ack_q;
   assign rsp_vld = rsp_vld_q;
   assign rsp_id  = rsp_id_q;
   assign rsp_ys  = rsp_ys_q;
   assign rsp_yc  = rsp_yc_q;
   assign rsp_err = rsp_err_q;
   assign busy    = busy_q;
   assign exp_ld  = exp_ld_q;
   assign exp_xs  = exp_xs_q;
   assign exp_xc  = exp_xc_q;

endmodule
